// File: rtl/adma_host_responder.sv
// Host-side req/ack responder and ADMA descriptor base-address register for the SD DMA/ADMA engine.
// Optional per-channel WAIT stall input is enabled by defining ADMA_RESP_STALL_EN.
module adma_host_responder #(
    parameter int                ADDR_W      = 64,
    parameter int                N_CH        = 4,
    parameter int                DLY_W       = 4,
    parameter int                ADDR_STRIDE = 8,
    parameter logic [ADDR_W-1:0] ADDR_RST    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   req,
    output logic [N_CH-1:0]   ack,
    input  logic [DLY_W-1:0]  ack_delay,
`ifdef ADMA_RESP_STALL_EN
    input  logic [N_CH-1:0]   stall,
`endif
    input  logic [ADDR_W-1:0] addr_init,
    input  logic              addr_load,
    input  logic              addr_next,
    output logic [ADDR_W-1:0] Initial_ADMA_System_Address,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_ACK  = 2'b10
    } state_t;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [DLY_W-1:0] cnt_q   [N_CH];
    logic [DLY_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  stall_i;

`ifdef ADMA_RESP_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = '0;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (req[i]) begin
                        cnt_d[i]   = ack_delay;
                        state_d[i] = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An abort wins over a stall; the delay was latched on entry.
                    if (!req[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (stall_i[i]) begin
                        state_d[i] = S_WAIT;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = S_ACK;
                    end else begin
                        cnt_d[i] = cnt_q[i] - DLY_W'(1);
                    end
                end
                S_ACK: begin
                    if (!req[i]) state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ack  = '0;
        busy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            ack[i] = (state_q[i] == S_ACK);
            busy   = busy | (state_q[i] != S_IDLE);
        end
    end

    // Load beats increment; the add wraps silently at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            Initial_ADMA_System_Address <= ADDR_RST;
        end else if (addr_load) begin
            Initial_ADMA_System_Address <= addr_init;
        end else if (addr_next) begin
            Initial_ADMA_System_Address <= Initial_ADMA_System_Address + ADDR_W'(ADDR_STRIDE);
        end
    end

endmodule

// File: tb/tb_adma_host_responder.sv
// Self-checking bench for adma_host_responder: deadline-based channel model plus directed vectors.
// Stall scenarios run only when ADMA_RESP_STALL_EN is defined.
module tb_adma_host_responder;

    localparam int ADDR_W = 64;
    localparam int N_CH   = 4;
    localparam int DLY_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   ack;
    logic [DLY_W-1:0]  ack_delay;
    logic [N_CH-1:0]   stall;
    logic [ADDR_W-1:0] addr_init;
    logic              addr_load;
    logic              addr_next;
    logic [ADDR_W-1:0] addr;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adma_host_responder #(
        .ADDR_W(ADDR_W), .N_CH(N_CH), .DLY_W(DLY_W), .ADDR_STRIDE(8), .ADDR_RST(64'd1)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .req                         (req),
        .ack                         (ack),
        .ack_delay                   (ack_delay),
`ifdef ADMA_RESP_STALL_EN
        .stall                       (stall),
`endif
        .addr_init                   (addr_init),
        .addr_load                   (addr_load),
        .addr_next                   (addr_next),
        .Initial_ADMA_System_Address (addr),
        .busy                        (busy)
    );

    // Model: each accepted request gets an absolute ack deadline (edge count);
    // stalled edges push the deadline out by one.
    int                cyc = 0;
    logic [N_CH-1:0]   m_pend = '0;
    logic [N_CH-1:0]   m_ack  = '0;
    int                m_due [N_CH];
    logic [ADDR_W-1:0] m_addr = '0;
    logic [N_CH-1:0]   stall_eff;

`ifdef ADMA_RESP_STALL_EN
    assign stall_eff = stall;
`else
    assign stall_eff = '0;
`endif

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_pend <= '0;
            m_ack  <= '0;
            m_addr <= 64'd1;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (m_ack[i]) begin
                    if (!req[i]) m_ack[i] <= 1'b0;
                end else if (m_pend[i]) begin
                    if (!req[i]) m_pend[i] <= 1'b0;
                    else if (stall_eff[i]) m_due[i] <= m_due[i] + 1;
                    else if (cyc == m_due[i]) begin
                        m_pend[i] <= 1'b0;
                        m_ack[i]  <= 1'b1;
                    end
                end else if (req[i]) begin
                    m_pend[i] <= 1'b1;
                    m_due[i]  <= cyc + int'(ack_delay) + 1;
                end
            end
            if (addr_load)      m_addr <= addr_init;
            else if (addr_next) m_addr <= m_addr + 64'd8;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("model_ack",  64'(ack),  64'(m_ack));
            check("model_busy", 64'(busy), 64'(|(m_pend | m_ack)));
            check("model_addr", addr, m_addr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dl[4];
        dl[0] = 0; dl[1] = 1; dl[2] = 2; dl[3] = 15;
        reset = 1'b1; req = '0; ack_delay = '0; stall = '0;
        addr_init = '0; addr_load = 1'b0; addr_next = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_ack",  64'(ack),  64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", addr,      64'd1);

        // Delay 3 on channel 2: ack high after E0+4.
        req[2] = 1'b1; ack_delay = 4'd3;
        tick(4);
        check("d3_ack_early", 64'(ack[2]), 64'd0);
        tick(1);
        check("d3_ack", 64'(ack[2]), 64'd1);
        req[2] = 1'b0;
        tick(1);
        check("d3_release_ack",  64'(ack[2]), 64'd0);
        check("d3_release_busy", 64'(busy),   64'd0);

        // Channel 0 with D=0, channel 1 with D=5; ack_delay changed mid-WAIT.
        req[0] = 1'b1; ack_delay = 4'd0;
        tick(1);
        check("ch0_wait", 64'(ack[0]), 64'd0);
        req[1] = 1'b1; ack_delay = 4'd5;
        tick(1);
        ack_delay = 4'd0;
        check("ch0_ack", 64'(ack[0]), 64'd1);
        tick(5);
        check("ch1_early", 64'(ack[1]), 64'd0);
        tick(1);
        check("ch1_ack",   64'(ack[1]), 64'd1);
        check("ch23_idle", 64'(ack[3:2]), 64'd0);
        req = '0;
        tick(1);
        check("multi_release_busy", 64'(busy), 64'd0);

        // Abort in WAIT.
        req[3] = 1'b1; ack_delay = 4'd7;
        tick(3);
        req[3] = 1'b0;
        tick(2);
        check("abort_busy", 64'(busy), 64'd0);
        tick(10);
        check("abort_no_ack", 64'(ack), 64'd0);

        // Back-to-back handshakes: latency in falling edges is D+2 from raising req.
        for (int k = 0; k < 8; k++) begin
            req[k % N_CH] = 1'b1; ack_delay = DLY_W'(dl[k % 4]);
            lat = 0;
            while (!ack[k % N_CH] && lat < 40) begin
                tick(1);
                lat++;
            end
            check("hs_latency", 64'(lat), 64'(dl[k % 4] + 2));
            req[k % N_CH] = 1'b0;
            tick(1);
        end

        // Address wrap and load priority.
        addr_init = 64'hFFFF_FFFF_FFFF_FFF8; addr_load = 1'b1;
        tick(1);
        addr_load = 1'b0;
        check("addr_load", addr, 64'hFFFF_FFFF_FFFF_FFF8);
        addr_next = 1'b1;
        tick(1);
        addr_next = 1'b0;
        check("addr_wrap", addr, 64'h0);
        addr_init = 64'h100; addr_load = 1'b1; addr_next = 1'b1;
        tick(1);
        addr_load = 1'b0;
        check("addr_prio", addr, 64'h100);
        tick(1);
        addr_next = 1'b0;
        check("addr_next", addr, 64'h108);

        // Reset during ACK, with req held through reset.
        req[0] = 1'b1; ack_delay = 4'd0;
        tick(2);
        check("pre_rst_ack", 64'(ack[0]), 64'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_ack",  64'(ack),  64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_addr", addr,      64'd1);
        reset = 1'b0;
        tick(1);
        check("post_rst_busy", 64'(busy),   64'd1);
        tick(1);
        check("post_rst_ack",  64'(ack[0]), 64'd1);
        req = '0;
        tick(1);

`ifdef ADMA_RESP_STALL_EN
        // Stall for 10 edges with D=2: ack 3 edges after stall drops.
        req[1] = 1'b1; stall[1] = 1'b1; ack_delay = 4'd2;
        tick(10);
        stall[1] = 1'b0;
        tick(2);
        check("stall_early", 64'(ack[1]), 64'd0);
        tick(1);
        check("stall_ack", 64'(ack[1]), 64'd1);
        // Abort honoured while stalled.
        req[1] = 1'b0;
        tick(1);
        req[2] = 1'b1; stall[2] = 1'b1;
        tick(3);
        req[2] = 1'b0;
        tick(1);
        check("stall_abort_busy", 64'(busy), 64'd0);
        stall = '0;
        // Reset during ACK.
        req[3] = 1'b1; ack_delay = 4'd0;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("stall_rst_ack", 64'(ack), 64'd0);
        reset = 1'b0; req = '0;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
